// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: FPU dispatch with a completion-time schedule driving one writeback per cycle
module fpu_issue_sched #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 3,
  parameter int LAT_INV  = 3,
  parameter int LAT_SQRT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [31:0] inst,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  output logic        issue_ready,
  output logic [3:0]  u_start,
  output logic [31:0] u_a,
  output logic [31:0] u_b,
  input  logic [31:0] add_res,
  input  logic [31:0] mul_res,
  input  logic [31:0] inv_res,
  input  logic [31:0] sqrt_res,
  output logic        wb_enable,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        wb_float,
  output logic [31:0] pending
);
  localparam int DA = LAT_ADD > LAT_MUL ? LAT_ADD : LAT_MUL;
  localparam int DB = LAT_INV > LAT_SQRT ? LAT_INV : LAT_SQRT;
  localparam int DEPTH = DA > DB ? DA : DB;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [1:0] src;
  } ent_t;
  ent_t [DEPTH-1:0] sched;
  ent_t [DEPTH:0]   ext;
  logic [5:0] op;
  logic [4:0] rd;
  logic [1:0] src;
  logic       fpu_op, busy, accept;
  int         lat;
  assign op = inst[31:26];
  assign rd = inst[15:11];
  assign fpu_op = op >= 6'h30 && op <= 6'h35;
  assign src = op == 6'h35 ? 2'd3 : op[2:1];
  assign lat = src == 2'd0 ? LAT_ADD : src == 2'd1 ? LAT_MUL : src == 2'd2 ? LAT_INV : LAT_SQRT;
  assign ext = {ent_t'('0), sched};
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | (i == lat && sched[i].v);
  end
  assign issue_ready = rst_n & ~flush & (~fpu_op | (~pending[rd] & ~busy));
  assign accept = issue_valid & fpu_op & issue_ready;
  assign u_start = accept ? 4'b0001 << src : 4'b0000;
  assign u_a = accept ? rs : '0;
  assign u_b = (!accept || src == 2'd3) ? '0 : op[0] ? {~rt[31], rt[30:0]} : rt;
  assign wb_enable = rst_n & sched[0].v;
  assign wb_addr = wb_enable ? sched[0].rd : '0;
  assign wb_data = !wb_enable ? '0 : sched[0].src == 2'd0 ? add_res : sched[0].src == 2'd1 ? mul_res :
                   sched[0].src == 2'd2 ? inv_res : sqrt_res;
  assign wb_float = 1'b1;
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      sched <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) sched[i] <= (accept && i == lat - 1) ? {1'b1, rd, src} : ext[i+1];
      pending <= (pending & ~(wb_enable ? 32'd1 << wb_addr : 32'd0)) | (accept ? 32'd1 << rd : 32'd0);
    end
endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb_fpu_issue_sched: table vectors, hand sequences and a writeback scoreboard for the FPU scheduler
module tb_fpu_issue_sched;
  localparam int LA = 3, LM = 2, LI = 4, LS = 6;
  logic        clk = 0, rst_n = 0, issue_valid = 0, flush = 0;
  logic [31:0] inst = 0, rs = 0, rt = 0;
  logic        issue_ready, wb_enable, wb_float;
  logic [3:0]  u_start;
  logic [31:0] u_a, u_b, add_res, mul_res, inv_res, sqrt_res, wb_data, pending;
  logic [4:0]  wb_addr;
  int          tcyc = 0, n_cmp = 0, n_bad = 0;
  bit          chk_on = 0;
  typedef struct {
    int          at;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t         sb[$];
  logic [31:0] mp = 0;
  typedef struct {
    logic        v;
    logic [31:0] inst, rs, rt;
    logic        rdy;
    logic [3:0]  st;
    logic [31:0] a, b;
  } vec_t;
  vec_t tbl[15];

  fpu_issue_sched #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_INV(LI), .LAT_SQRT(LS)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .inst(inst), .rs(rs), .rt(rt),
    .flush(flush), .issue_ready(issue_ready), .u_start(u_start), .u_a(u_a), .u_b(u_b),
    .add_res(add_res), .mul_res(mul_res), .inv_res(inv_res), .sqrt_res(sqrt_res),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data), .wb_float(wb_float),
    .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;
  assign add_res  = 32'hA000_0000 + 32'(tcyc);
  assign mul_res  = 32'hB000_0000 + 32'(tcyc);
  assign inv_res  = 32'hC000_0000 + 32'(tcyc);
  assign sqrt_res = 32'hD000_0000 + 32'(tcyc);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, tcyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd);
    return {op, 10'd0, rd, 11'd0};
  endfunction

  task automatic go(input logic v, input logic [31:0] i, input logic [31:0] a = 32'd0,
                    input logic [31:0] b = 32'd0, input logic fl = 1'b0, input logic rn = 1'b1);
    @(posedge clk);
    #1;
    issue_valid = v;
    inst = i;
    rs = a;
    rt = b;
    flush = fl;
    rst_n = rn;
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : model
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        fpu, taken, rdy, acc;
    int          L, u, hi;
    logic [31:0] eb, ub;
    if (chk_on) begin
      op = inst[31:26];
      rd = inst[15:11];
      fpu = 1;
      L = 0;
      u = 0;
      case (op)
        6'h30, 6'h31: begin u = 0; L = LA; end
        6'h32, 6'h33: begin u = 1; L = LM; end
        6'h34: begin u = 2; L = LI; end
        6'h35: begin u = 3; L = LS; end
        default: fpu = 0;
      endcase
      taken = 0;
      hi = -1;
      foreach (sb[i]) begin
        if (sb[i].at == tcyc + L) taken = 1;
        if (sb[i].at == tcyc) hi = i;
      end
      rdy = rst_n && !flush && (!fpu || (!mp[rd] && !taken));
      acc = issue_valid && fpu && rdy;
      eb = u == 3 ? 32'd0 : op[0] ? rt ^ 32'h8000_0000 : rt;
      ub = u == 0 ? 32'hA000_0000 : u == 1 ? 32'hB000_0000 : u == 2 ? 32'hC000_0000 : 32'hD000_0000;
      chk("issue_ready", 64'(issue_ready), 64'(rdy));
      chk("u_start", 64'(u_start), acc ? 64'(4'b0001 << u) : 64'd0);
      chk("u_a", 64'(u_a), acc ? 64'(rs) : 64'd0);
      chk("u_b", 64'(u_b), acc ? 64'(eb) : 64'd0);
      chk("pending", 64'(pending), 64'(mp));
      chk("wb_float", 64'(wb_float), 64'd1);
      if (hi >= 0 && rst_n) chk("wb", 64'({wb_enable, wb_addr, wb_data}), 64'({1'b1, sb[hi].rd, sb[hi].data}));
      else chk("wb", 64'({wb_enable, wb_addr, wb_data}), 64'd0);
      if (!rst_n || flush) begin
        sb.delete();
        mp = 0;
      end else begin
        if (hi >= 0) begin
          mp[sb[hi].rd] = 0;
          sb.delete(hi);
        end
        if (acc) begin
          mp[rd] = 1;
          sb.push_back('{tcyc + L, rd, ub + 32'(tcyc + L)});
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{1, mk(6'h30, 1), 32'h3F800000, 32'h40000000, 1, 4'b0001, 32'h3F800000, 32'h40000000};
    tbl[1]  = '{1, mk(6'h31, 2), 32'h3F800000, 32'h40000000, 1, 4'b0001, 32'h3F800000, 32'hC0000000};
    tbl[2]  = '{1, mk(6'h32, 3), 32'h11111111, 32'h12345678, 0, 4'b0000, 32'h0, 32'h0};
    tbl[3]  = '{1, mk(6'h33, 3), 32'h00000005, 32'hC0400000, 1, 4'b0010, 32'h5, 32'h40400000};
    tbl[4]  = '{1, mk(6'h34, 4), 32'h40800000, 32'h00000077, 1, 4'b0100, 32'h40800000, 32'h77};
    tbl[5]  = '{1, mk(6'h35, 5), 32'h40800000, 32'h00000099, 1, 4'b1000, 32'h40800000, 32'h0};
    tbl[6]  = '{1, mk(6'h00, 1), 32'h1, 32'h2, 1, 4'b0000, 32'h0, 32'h0};
    tbl[7]  = '{1, mk(6'h36, 1), 32'h1, 32'h2, 1, 4'b0000, 32'h0, 32'h0};
    tbl[8]  = '{1, mk(6'h30, 4), 32'h1, 32'h2, 0, 4'b0000, 32'h0, 32'h0};
    tbl[9]  = '{0, mk(6'h30, 6), 32'h1, 32'h2, 1, 4'b0000, 32'h0, 32'h0};
    tbl[10] = '{1, mk(6'h30, 5), 32'h1, 32'h2, 0, 4'b0000, 32'h0, 32'h0};
    tbl[11] = '{1, mk(6'h30, 5), 32'h1, 32'h2, 0, 4'b0000, 32'h0, 32'h0};
    tbl[12] = '{1, mk(6'h30, 5), 32'h3, 32'h4, 1, 4'b0001, 32'h3, 32'h4};
    tbl[13] = '{1, mk(6'h30, 6), 32'h5, 32'h6, 1, 4'b0001, 32'h5, 32'h6};
    tbl[14] = '{1, mk(6'h30, 7), 32'h7, 32'h80000001, 1, 4'b0001, 32'h7, 32'h80000001};
    go(0, 0, 0, 0, 0, 0);
    chk_on = 1;
    go(1, mk(6'h30, 3), 1, 2, 0, 0);
    chk("rst issue_ready", 64'(issue_ready), 64'd0);
    chk("rst u_start", 64'(u_start), 64'd0);
    chk("rst wb", 64'({wb_enable, wb_addr, wb_data}), 64'd0);
    chk("rst pending", 64'(pending), 64'd0);
    foreach (tbl[k]) begin
      go(tbl[k].v, tbl[k].inst, tbl[k].rs, tbl[k].rt);
      chk($sformatf("tbl%0d ready", k), 64'(issue_ready), 64'(tbl[k].rdy));
      chk($sformatf("tbl%0d u_start", k), 64'(u_start), 64'(tbl[k].st));
      chk($sformatf("tbl%0d u_a", k), 64'(u_a), 64'(tbl[k].a));
      chk($sformatf("tbl%0d u_b", k), 64'(u_b), 64'(tbl[k].b));
    end
    repeat (8) go(0, 0);
    go(1, mk(6'h35, 4), 32'h40800000, 32'h1);
    go(0, 0);
    go(0, 0);
    go(1, mk(6'h30, 5), 1, 2);
    chk("t3 stall", 64'(issue_ready), 64'd0);
    go(1, mk(6'h30, 5), 1, 2);
    chk("t3 accept", 64'(issue_ready), 64'd1);
    go(0, 0);
    go(0, 0);
    chk("t3 wb f4", 64'({wb_enable, wb_addr}), 64'({1'b1, 5'd4}));
    go(0, 0);
    chk("t3 wb f5", 64'({wb_enable, wb_addr}), 64'({1'b1, 5'd5}));
    repeat (2) go(0, 0);
    go(1, mk(6'h32, 7), 1, 2);
    go(1, mk(6'h30, 7), 3, 4);
    chk("t4 stall1", 64'(issue_ready), 64'd0);
    chk("t4 pend1", 64'(pending), 64'h80);
    go(1, mk(6'h30, 7), 3, 4);
    chk("t4 stall2", 64'(issue_ready), 64'd0);
    chk("t4 pend2", 64'(pending), 64'h80);
    chk("t4 wb", 64'({wb_enable, wb_addr}), 64'({1'b1, 5'd7}));
    go(1, mk(6'h30, 7), 3, 4);
    chk("t4 accept", 64'(issue_ready), 64'd1);
    repeat (4) go(0, 0);
    go(1, mk(6'h30, 1), 1, 2);
    go(1, mk(6'h30, 2), 3, 4);
    go(1, mk(6'h32, 9), 5, 6, 1);
    chk("t5 flush ready", 64'(issue_ready), 64'd0);
    chk("t5 flush start", 64'(u_start), 64'd0);
    go(0, 0);
    chk("t5 pending", 64'(pending), 64'd0);
    chk("t5 no wb f1", 64'(wb_enable), 64'd0);
    go(0, 0);
    chk("t5 no wb f2", 64'(wb_enable), 64'd0);
    repeat (4) go(0, 0);
    go(1, mk(6'h35, 10), 1, 2);
    go(1, mk(6'h32, 12), 3, 4);
    go(1, mk(6'h30, 11), 5, 6);
    go(1, mk(6'h30, 13), 7, 8, 0, 0);
    chk("t6 rst ready", 64'(issue_ready), 64'd0);
    chk("t6 rst start", 64'(u_start), 64'd0);
    chk("t6 rst wb", 64'({wb_enable, wb_addr, wb_data}), 64'd0);
    go(0, 0);
    chk("t6 pending", 64'(pending), 64'd0);
    repeat (7) go(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
